memtrace_issue_ctrl: RTL

// - Sequences the DPI memory-trace reader. Drives its cycle index and ready, and latches one multi-lane trace row.
// - Issues the row's valid lanes one at a time onto a single shared memory request port, using round-robin lane arbitration.
// - Tracks outstanding requests and reports completion once the trace is finished and fully drained.
// - Sits between the trace reader and the memory-system adapter in the trace-driven test harness.

---
 rtl/memtrace_issue_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/memtrace_issue_ctrl.sv
// Trace-driven memory request sequencer: fetches one multi-lane trace row, issues its lanes round-robin.
// Optional statistics counters are compiled in when MEMTRACE_ISSUE_STATS_EN is defined.
module memtrace_issue_ctrl #(
  parameter int NUM_LANES       = 4,
  parameter int LANE_W          = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int LOGSIZE_WIDTH   = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic [63:0]                      trace_read_cycle,
  output logic                             trace_read_ready,
  input  logic [NUM_LANES-1:0]             trace_read_valid,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]  trace_read_address,
  input  logic [NUM_LANES-1:0]             trace_read_is_store,
  input  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] trace_read_size,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]  trace_read_data,
  input  logic                             trace_read_finished,
  output logic                             req_valid,
  input  logic                             req_ready,
  output logic [LANE_W-1:0]                req_lane,
  output logic [DATA_WIDTH-1:0]            req_address,
  output logic [DATA_WIDTH-1:0]            req_data,
  output logic                             req_is_store,
  output logic [LOGSIZE_WIDTH-1:0]         req_size,
  input  logic                             resp_valid,
  output logic [7:0]                       outstanding,
  output logic                             done,
`ifdef MEMTRACE_ISSUE_STATS_EN
  output logic                             err_underflow,
  output logic [31:0]                      stat_loads,
  output logic [31:0]                      stat_stores,
  output logic [31:0]                      stat_stall_cycles
`else
  output logic                             err_underflow
`endif
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]               state;
  logic [NUM_LANES-1:0]     pending;
  logic [NUM_LANES-1:0]     pending_next;
  logic [LANE_W-1:0]        rr_ptr;
  logic [LANE_W-1:0]        grant;
  logic [LANE_W-1:0]        cand;
  logic                     found;
  logic                     below_limit;
  logic                     issue;
  logic                     resp_dec;
  logic [7:0]               outstanding_next;

  logic [DATA_WIDTH-1:0]    addr_q [NUM_LANES];
  logic [DATA_WIDTH-1:0]    data_q [NUM_LANES];
  logic [LOGSIZE_WIDTH-1:0] size_q [NUM_LANES];
  logic [NUM_LANES-1:0]     store_q;

  function automatic logic [LANE_W-1:0] lane_wrap(input int v);
    return LANE_W'(v % NUM_LANES);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Round-robin search: first pending lane at or after rr_ptr, wrapping.
  always_comb begin
    grant = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = lane_wrap(int'(rr_ptr) + i);
      if (!found && pending[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign below_limit      = outstanding < 8'(MAX_OUTSTANDING);
  assign req_valid        = (state == ST_ISSUE) && (pending != '0) && below_limit;
  assign issue            = req_valid && req_ready;
  assign resp_dec         = resp_valid && (outstanding != 8'd0);
  assign outstanding_next = outstanding + 8'(issue) - 8'(resp_dec);
  assign pending_next     = pending & ~(NUM_LANES'(1) << grant);

  assign trace_read_ready = (state == ST_FETCH);
  assign done             = (state == ST_DONE);
  assign req_lane         = grant;
  assign req_address      = addr_q[grant];
  assign req_data         = data_q[grant];
  assign req_is_store     = store_q[grant];
  assign req_size         = size_q[grant];

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_FETCH;
      trace_read_cycle <= '0;
      rr_ptr           <= '0;
      pending          <= '0;
      outstanding      <= '0;
      err_underflow    <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      if (resp_valid && outstanding == 8'd0)
        err_underflow <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (|trace_read_valid) begin
            pending <= trace_read_valid;
            state   <= ST_ISSUE;
          end else if (trace_read_finished) begin
            state <= ST_DRAIN;
          end else begin
            trace_read_cycle <= trace_read_cycle + 64'd1;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            pending <= pending_next;
            rr_ptr  <= lane_wrap(int'(grant) + 1);
            if (pending_next == '0) begin
              trace_read_cycle <= trace_read_cycle + 64'd1;
              state            <= ST_FETCH;
            end
          end
        end
        ST_DRAIN: begin
          if (outstanding_next == 8'd0)
            state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // Row payload is held unreset; only the pending mask decides what is live.
  always_ff @(posedge clock) begin
    if (state == ST_FETCH && |trace_read_valid) begin
      for (int g = 0; g < NUM_LANES; g++) begin
        addr_q[g]  <= trace_read_address[DATA_WIDTH*g +: DATA_WIDTH];
        data_q[g]  <= trace_read_data[DATA_WIDTH*g +: DATA_WIDTH];
        size_q[g]  <= trace_read_size[LOGSIZE_WIDTH*g +: LOGSIZE_WIDTH];
        store_q[g] <= trace_read_is_store[g];
      end
    end
  end

`ifdef MEMTRACE_ISSUE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_loads        <= '0;
      stat_stores       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (issue && req_is_store)
        stat_stores <= sat_inc(stat_stores);
      if (issue && !req_is_store)
        stat_loads <= sat_inc(stat_loads);
      if ((req_valid && !req_ready) || (state == ST_ISSUE && pending != '0 && !below_limit))
        stat_stall_cycles <= sat_inc(stat_stall_cycles);
    end
  end
`endif

endmodule
